sfft_peak_finder: RTL
=====================

Name: sfft_peak_finder

Overview:
- Downstream consumer of the SFFT pipeline's per-frame bin stream.
- Computes an approximate magnitude for each bin and tracks the strongest bin in each of NUM_BANDS equal-width frequency bands.
- At frame end, commits the band peaks plus a frame counter into a result buffer that the bus read logic reads.
- Result-buffer updates are blocked while software holds read_lock, so each frame's peaks reach the driver without tearing.

Parameters:
- N_BINS, 256, bins per frame (NFFT/2); power of two.
- BIN_W, 8, log2(N_BINS).
- NUM_BANDS, 8, number of equal-width bands; power of two, divides N_BINS.
- BAND_W, 3, log2(NUM_BANDS).
- DATA_W, 24, width of signed real/imag bin components.
- CNT_W, 32, frame counter width.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- bin_valid  in  1  bin data valid this cycle; no backpressure, accepted every valid cycle.
- bin_index  in  BIN_W  index of presented bin.
- bin_real  in  DATA_W  signed real component.
- bin_imag  in  DATA_W  signed imaginary component.
- threshold  in  DATA_W+1  unsigned presence threshold.
- read_lock  in  1  high while software reads; freezes committed results.
- clear_flags  in  1  single-cycle pulse; clears sticky flags.
- rd_band  in  BAND_W  band select for readout.
- rd_mag  out  DATA_W+1  committed peak magnitude of rd_band.
- rd_index  out  BIN_W  committed peak bin index of rd_band.
- rd_present  out  1  committed rd_mag >= threshold, evaluated at commit.
- frame_count  out  CNT_W  number of committed frames.
- peaks_valid  out  1  one-cycle pulse on commit.
- overrun  out  1  sticky: a completed frame was dropped due to read_lock.
- seq_error  out  1  sticky: out-of-sequence bin abandoned a frame.

Behaviour:
- Reset (reset low, async):
  - committed buffer entries are 0 (mag, index, present).
  - frame_count=0, peaks_valid=0, overrun=0, seq_error=0.
  - working maxima cleared; FSM goes to IDLE.
- Magnitude: mag = |bin_real| + |bin_imag|, unsigned DATA_W+1 bits. |-2^(DATA_W-1)| = 2^(DATA_W-1) is exact; no saturation is needed.
- Band: band = bin_index >> (BIN_W-BAND_W).
- Pipeline:
  - Edge 1: register mag, index, band and a last flag.
  - Edge 2: compare with that band's working max and update on strict greater-than. Ties keep the lower index.
  - Working maxima are cleared when bin 0 is accepted; bin 0 always loads its band.
- FSM states:
  - IDLE: wait for bin_valid with index 0 → SCAN (expect=1). Nonzero indices are ignored silently.
  - SCAN:
    - Valid index == expect: accept and increment expect.
    - Index N_BINS-1 accepted → COMMIT after the pipeline drains.
    - Valid index 0: restart the frame (clear maxima, expect=1) and set seq_error.
    - Any other mismatch: abandon the frame, set seq_error, go to IDLE.
    - Gaps in bin_valid are allowed.
  - COMMIT (one cycle):
    - read_lock low: copy all working maxima to the committed buffer, evaluate rd_present per band against the current threshold, increment frame_count (wraps), pulse peaks_valid.
    - read_lock high: discard, set overrun; frame_count and buffer unchanged, no pulse.
    - Either way → IDLE.
    - A bin 0 arriving during COMMIT is accepted and starts the next frame (SCAN).
- Latency: peaks_valid is high in the cycle following the 3rd rising edge after the cycle in which bin N_BINS-1 was accepted.
- Readout: rd_mag, rd_index and rd_present are combinational from the committed buffer indexed by rd_band. They are stable whenever read_lock is high.
- Sticky flags:
  - clear_flags clears overrun and seq_error.
  - If clear_flags coincides with a new set event, set wins.
- Back-to-back frames at one bin per cycle: supported without loss when read_lock is low.

Test Plan:
- Ramp frame: bin i with real=i, imag=0, N_BINS=256, NUM_BANDS=8 → every band k reports index 32k+31, mag 32k+31. peaks_valid pulses 3 edges after bin 255; frame_count=1.
- Negative extreme: bin 40 with real=-8388608, imag=-8388608, all other bins 0 → band 1 mag=16777216 (0x1000000), index 40. With threshold=100, band 1 present=1 and all others present=0.
- Tie: bins 64 and 70 both mag 500, rest 0 → band 2 index 64.
- Lock overrun: hold read_lock high over the end of frame 2 → overrun=1, frame_count stays 1, buffer keeps frame-1 values. clear_flags → overrun=0.
- Sequence error: send bins 0..9 then 12 → seq_error=1, no commit. Next full frame commits normally with frame_count+1. Also bin 0 mid-scan → restart, seq_error=1.
- Reset mid-scan at bin 100, then a full frame → no commit from the partial frame; frame_count=1 after the full frame.

Source files
------------

// File: rtl/sfft_peak_finder.sv
// Per-band peak tracker for the SFFT bin stream with a lockable committed result buffer.
module sfft_peak_finder #(
    parameter int unsigned N_BINS    = 256,
    parameter int unsigned BIN_W     = 8,
    parameter int unsigned NUM_BANDS = 8,
    parameter int unsigned BAND_W    = 3,
    parameter int unsigned DATA_W    = 24,
    parameter int unsigned CNT_W     = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              bin_valid,
    input  logic [BIN_W-1:0]  bin_index,
    input  logic [DATA_W-1:0] bin_real,
    input  logic [DATA_W-1:0] bin_imag,
    input  logic [DATA_W:0]   threshold,
    input  logic              read_lock,
    input  logic              clear_flags,
    input  logic [BAND_W-1:0] rd_band,
    output logic [DATA_W:0]   rd_mag,
    output logic [BIN_W-1:0]  rd_index,
    output logic              rd_present,
    output logic [CNT_W-1:0]  frame_count,
    output logic              peaks_valid,
    output logic              overrun,
    output logic              seq_error
);

    localparam int unsigned       MAG_W    = DATA_W + 1;
    localparam logic [BIN_W-1:0]  LAST_IDX = BIN_W'(N_BINS - 1);

    typedef enum logic {
        ST_IDLE,
        ST_SCAN
    } state_e;

    state_e             state_q, state_d;
    logic [BIN_W-1:0]   expect_q, expect_d;
    logic               accept_c, first_c, last_c, seq_set_c;
    logic [MAG_W-1:0]   mag_c;

    logic               s1_valid_q, s1_first_q, s1_last_q;
    logic [MAG_W-1:0]   s1_mag_q;
    logic [BIN_W-1:0]   s1_index_q;
    logic [BAND_W-1:0]  s1_band_q;

    logic [MAG_W-1:0]   wmax_mag_q [NUM_BANDS];
    logic [BIN_W-1:0]   wmax_idx_q [NUM_BANDS];
    logic               commit_q;

    logic [MAG_W-1:0]   cbuf_mag_q  [NUM_BANDS];
    logic [BIN_W-1:0]   cbuf_idx_q  [NUM_BANDS];
    logic               cbuf_pres_q [NUM_BANDS];
    logic [CNT_W-1:0]   frame_cnt_q;
    logic               peaks_valid_q, overrun_q, seq_error_q;

    // Absolute value widened by one bit so the most negative input is exact.
    function automatic logic [MAG_W-1:0] abs_val(input logic [DATA_W-1:0] x);
        logic [MAG_W-1:0] ext;
        ext = {x[DATA_W-1], x};
        return x[DATA_W-1] ? (MAG_W'(0) - ext) : ext;
    endfunction

    assign mag_c = abs_val(bin_real) + abs_val(bin_imag);

    // Sequence tracker: frame state and expected bin index.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            expect_q <= '0;
        end else begin
            state_q  <= state_d;
            expect_q <= expect_d;
        end
    end

    // Bin acceptance and frame sequencing; the commit itself trails through the pipeline.
    always_comb begin
        state_d   = state_q;
        expect_d  = expect_q;
        accept_c  = 1'b0;
        first_c   = 1'b0;
        last_c    = 1'b0;
        seq_set_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bin_valid && bin_index == '0) begin
                    accept_c = 1'b1;
                    first_c  = 1'b1;
                    expect_d = BIN_W'(1);
                    state_d  = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (bin_valid) begin
                    if (bin_index == expect_q) begin
                        accept_c = 1'b1;
                        if (bin_index == LAST_IDX) begin
                            last_c  = 1'b1;
                            state_d = ST_IDLE;
                        end else begin
                            expect_d = expect_q + BIN_W'(1);
                        end
                    end else if (bin_index == '0) begin
                        accept_c  = 1'b1;
                        first_c   = 1'b1;
                        seq_set_c = 1'b1;
                        expect_d  = BIN_W'(1);
                    end else begin
                        seq_set_c = 1'b1;
                        state_d   = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Stage 1: register magnitude, index, band and frame markers of accepted bins.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid_q <= 1'b0;
            s1_first_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_mag_q   <= '0;
            s1_index_q <= '0;
            s1_band_q  <= '0;
        end else begin
            s1_valid_q <= accept_c;
            if (accept_c) begin
                s1_first_q <= first_c;
                s1_last_q  <= last_c;
                s1_mag_q   <= mag_c;
                s1_index_q <= bin_index;
                s1_band_q  <= bin_index[BIN_W-1 -: BAND_W];
            end
        end
    end

    // Stage 2: per-band running maxima; bin 0 clears all bands and loads its own.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned b = 0; b < NUM_BANDS; b++) begin
                wmax_mag_q[b] <= '0;
                wmax_idx_q[b] <= '0;
            end
            commit_q <= 1'b0;
        end else begin
            commit_q <= s1_valid_q & s1_last_q;
            if (s1_valid_q) begin
                if (s1_first_q) begin
                    for (int unsigned b = 0; b < NUM_BANDS; b++) begin
                        wmax_mag_q[b] <= '0;
                        wmax_idx_q[b] <= '0;
                    end
                    wmax_mag_q[s1_band_q] <= s1_mag_q;
                    wmax_idx_q[s1_band_q] <= s1_index_q;
                end else if (s1_mag_q > wmax_mag_q[s1_band_q]) begin
                    wmax_mag_q[s1_band_q] <= s1_mag_q;
                    wmax_idx_q[s1_band_q] <= s1_index_q;
                end
            end
        end
    end

    // Commit: copy maxima to the result buffer unless software holds the lock.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned b = 0; b < NUM_BANDS; b++) begin
                cbuf_mag_q[b]  <= '0;
                cbuf_idx_q[b]  <= '0;
                cbuf_pres_q[b] <= 1'b0;
            end
            frame_cnt_q   <= '0;
            peaks_valid_q <= 1'b0;
        end else begin
            peaks_valid_q <= commit_q & ~read_lock;
            if (commit_q && !read_lock) begin
                for (int unsigned b = 0; b < NUM_BANDS; b++) begin
                    cbuf_mag_q[b]  <= wmax_mag_q[b];
                    cbuf_idx_q[b]  <= wmax_idx_q[b];
                    cbuf_pres_q[b] <= (wmax_mag_q[b] >= threshold);
                end
                frame_cnt_q <= frame_cnt_q + CNT_W'(1);
            end
        end
    end

    // Sticky flags; a set event outranks a simultaneous clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overrun_q   <= 1'b0;
            seq_error_q <= 1'b0;
        end else begin
            if (commit_q && read_lock) overrun_q <= 1'b1;
            else if (clear_flags)      overrun_q <= 1'b0;
            if (seq_set_c)             seq_error_q <= 1'b1;
            else if (clear_flags)      seq_error_q <= 1'b0;
        end
    end

    assign rd_mag      = cbuf_mag_q[rd_band];
    assign rd_index    = cbuf_idx_q[rd_band];
    assign rd_present  = cbuf_pres_q[rd_band];
    assign frame_count = frame_cnt_q;
    assign peaks_valid = peaks_valid_q;
    assign overrun     = overrun_q;
    assign seq_error   = seq_error_q;

endmodule
